// File: rtl/tl_ul_req_issuer.sv
// TL-UL A-channel request issuer: buffers host requests in a FIFO and issues them one at a time.
// Optional macro TL_REQ_TIMEOUT_EN bounds the wait for D-channel completion (TIMEOUT_CYCLES).
module tl_ul_req_issuer #(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [TL_OPCODE_WIDTH-1:0] req_opcode,
    input  logic [TL_PARAM_WIDTH-1:0]  req_param,
    input  logic [TL_ADDR_WIDTH-1:0]   req_address,
    input  logic [TL_SIZE_WIDTH-1:0]   req_size,
    input  logic [TL_STRB_WIDTH-1:0]   req_mask,
    input  logic [TL_DATA_WIDTH-1:0]   req_data,
    input  logic [TL_SOURCE_WIDTH-1:0] req_source,
    output logic                       a_valid_in,
    output logic [TL_OPCODE_WIDTH-1:0] a_opcode_in,
    output logic [TL_PARAM_WIDTH-1:0]  a_param_in,
    output logic [TL_ADDR_WIDTH-1:0]   a_address_in,
    output logic [TL_SIZE_WIDTH-1:0]   a_size_in,
    output logic [TL_STRB_WIDTH-1:0]   a_mask_in,
    output logic [TL_DATA_WIDTH-1:0]   a_data_in,
    output logic [TL_SOURCE_WIDTH-1:0] a_source_in,
    input  logic                       d_fire,
    output logic                       busy,
    output logic [7:0]                 illegal_cnt,
    output logic                       timeout_err
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = TL_OPCODE_WIDTH + TL_PARAM_WIDTH + TL_ADDR_WIDTH + TL_SIZE_WIDTH
                           + TL_STRB_WIDTH + TL_DATA_WIDTH + TL_SOURCE_WIDTH;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t state, state_next;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic               full, empty;
    logic               opcode_legal, push_fire, store_en, pop_en;
    logic               load_head, timeout_hit;

    logic [TL_OPCODE_WIDTH-1:0] head_opcode;
    logic [TL_PARAM_WIDTH-1:0]  head_param;
    logic [TL_ADDR_WIDTH-1:0]   head_address;
    logic [TL_SIZE_WIDTH-1:0]   head_size;
    logic [TL_STRB_WIDTH-1:0]   head_mask;
    logic [TL_DATA_WIDTH-1:0]   head_data;
    logic [TL_SOURCE_WIDTH-1:0] head_source;

    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign req_ready = !full;
    assign busy      = (state != ST_IDLE) || !empty;

    // Only PutFull, PutPartial and Get exist in TL-UL; everything else is swallowed and counted.
    assign opcode_legal = (req_opcode == TL_OPCODE_WIDTH'(0))
                       || (req_opcode == TL_OPCODE_WIDTH'(1))
                       || (req_opcode == TL_OPCODE_WIDTH'(4));
    assign push_fire    = req_valid && req_ready;
    assign store_en     = push_fire && opcode_legal;
    assign pop_en       = (state == ST_ISSUE);

    assign push_entry = {req_opcode, req_param, req_address, req_size, req_mask, req_data, req_source};
    assign head_entry = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign {head_opcode, head_param, head_address, head_size, head_mask, head_data, head_source} = head_entry;

    always_ff @(posedge clk) begin
        if (store_en) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (store_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_cnt <= '0;
        end else if (push_fire && !opcode_legal && (illegal_cnt != 8'hFF)) begin
            illegal_cnt <= illegal_cnt + 8'd1;
        end
    end

`ifdef TL_REQ_TIMEOUT_EN
    logic [15:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if ((state == ST_WAIT) && !d_fire && !timeout_hit) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_head   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_next = ST_ISSUE;
                    load_head  = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (d_fire) begin
                    state_next = ST_IDLE;
                end
`ifdef TL_REQ_TIMEOUT_EN
                else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_next  = ST_IDLE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Issued fields are captured as the FSM enters ISSUE and hold until the next issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid_in   <= 1'b0;
            a_opcode_in  <= '0;
            a_param_in   <= '0;
            a_address_in <= '0;
            a_size_in    <= '0;
            a_mask_in    <= '0;
            a_data_in    <= '0;
            a_source_in  <= '0;
        end else begin
            a_valid_in <= load_head;
            if (load_head) begin
                a_opcode_in  <= head_opcode;
                a_param_in   <= head_param;
                a_address_in <= head_address;
                a_size_in    <= head_size;
                a_mask_in    <= head_mask;
                a_data_in    <= head_data;
                a_source_in  <= head_source;
            end
        end
    end

endmodule

// File: tb/tb_tl_ul_req_issuer.sv
// Self-checking bench for tl_ul_req_issuer: queue-based reference model plus directed and random traffic.
// Timeout checks are compiled in when TL_REQ_TIMEOUT_EN is defined.
module tb_tl_ul_req_issuer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_opcode = '0;
    logic [2:0]  req_param = '0;
    logic [63:0] req_address = '0;
    logic [7:0]  req_size = '0;
    logic [7:0]  req_mask = '0;
    logic [63:0] req_data = '0;
    logic [2:0]  req_source = '0;
    logic        a_valid_in;
    logic [2:0]  a_opcode_in;
    logic [2:0]  a_param_in;
    logic [63:0] a_address_in;
    logic [7:0]  a_size_in;
    logic [7:0]  a_mask_in;
    logic [63:0] a_data_in;
    logic [2:0]  a_source_in;
    logic        d_fire = 1'b0;
    logic        busy;
    logic [7:0]  illegal_cnt;
    logic        timeout_err;

    always #5 clk = ~clk;

    tl_ul_req_issuer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_param    (req_param),
        .req_address  (req_address),
        .req_size     (req_size),
        .req_mask     (req_mask),
        .req_data     (req_data),
        .req_source   (req_source),
        .a_valid_in   (a_valid_in),
        .a_opcode_in  (a_opcode_in),
        .a_param_in   (a_param_in),
        .a_address_in (a_address_in),
        .a_size_in    (a_size_in),
        .a_mask_in    (a_mask_in),
        .a_data_in    (a_data_in),
        .a_source_in  (a_source_in),
        .d_fire       (d_fire),
        .busy         (busy),
        .illegal_cnt  (illegal_cnt),
        .timeout_err  (timeout_err)
    );

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [63:0] address;
        logic [7:0]  size;
        logic [7:0]  mask;
        logic [63:0] data;
        logic [2:0]  source;
    } req_t;

    // Reference model: pending requests, whether one is on the wire or outstanding, and counters.
    req_t mq[$];
    bit   m_issuing = 0;
    bit   m_waiting = 0;
    int   m_wait_cycles = 0;
    int   m_illegal = 0;
    bit   m_timeout = 0;
    req_t m_out = '0;

    int checks = 0;
    int errors = 0;

    bit d_auto = 0;
    bit d_manual = 0;
    int d_prob = 50;

    function automatic bit is_legal(logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout expected=completion at %0t", name, $time);
    endtask

    task automatic model_step();
        bit   start_issue;
        bit   push;
        req_t r;
        start_issue = !m_issuing && !m_waiting && (mq.size() != 0);
        push        = req_valid && (mq.size() < DEPTH);
        if (start_issue) m_out = mq[0];
        if (m_issuing) begin
            void'(mq.pop_front());
            m_waiting     = 1;
            m_wait_cycles = 0;
        end else if (m_waiting) begin
            if (d_fire) begin
                m_waiting = 0;
            end else begin
                m_wait_cycles++;
`ifdef TL_REQ_TIMEOUT_EN
                if (m_wait_cycles == TMO) begin
                    m_timeout = 1;
                    m_waiting = 0;
                end
`endif
            end
        end
        if (push) begin
            if (is_legal(req_opcode)) begin
                r = '{req_opcode, req_param, req_address, req_size, req_mask, req_data, req_source};
                mq.push_back(r);
            end else if (m_illegal < 255) begin
                m_illegal++;
            end
        end
        m_issuing = start_issue;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_issuing     = 0;
            m_waiting     = 0;
            m_wait_cycles = 0;
            m_illegal     = 0;
            m_timeout     = 0;
            m_out         = '0;
        end else begin
            model_step();
        end
    end

    // Every cycle, all outputs are compared against the model away from the clock edge.
    initial forever begin
        @(negedge clk);
        check_output("a_valid_in", 64'(a_valid_in), 64'(m_issuing));
        check_output("a_opcode_in", 64'(a_opcode_in), 64'(m_out.opcode));
        check_output("a_param_in", 64'(a_param_in), 64'(m_out.param));
        check_output("a_address_in", a_address_in, m_out.address);
        check_output("a_size_in", 64'(a_size_in), 64'(m_out.size));
        check_output("a_mask_in", 64'(a_mask_in), 64'(m_out.mask));
        check_output("a_data_in", a_data_in, m_out.data);
        check_output("a_source_in", 64'(a_source_in), 64'(m_out.source));
        check_output("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
        check_output("busy", 64'(busy), 64'(m_issuing || m_waiting || (mq.size() != 0)));
        check_output("illegal_cnt", 64'(illegal_cnt), 64'(m_illegal));
        check_output("timeout_err", 64'(timeout_err), 64'(m_timeout));
    end

    initial forever begin
        @(negedge clk);
        #2;
        d_fire = d_auto ? (int'($urandom_range(99)) < d_prob) : d_manual;
    end

    initial begin
        #600000;
        report_fail("watchdog");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [63:0] addr, input logic [2:0] src);
        bit done;
        bit ok;
        done        = 0;
        req_opcode  = op;
        req_address = addr;
        req_source  = src;
        req_param   = 3'($urandom_range(7));
        req_size    = 8'($urandom_range(255));
        req_mask    = 8'($urandom_range(255));
        req_data    = {$urandom, $urandom};
        req_valid   = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            ok = req_ready;
            step(1);
            if (ok) done = 1;
        end
        req_valid = 1'b0;
        if (!done) report_fail("push_accept");
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (!busy) done = 1;
            else step(1);
        end
        if (!done) report_fail("drain");
    endtask

    initial begin
        logic [2:0] op;
        #1 rst = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        check_output("reset_req_ready", 64'(req_ready), 64'd1);
        check_output("reset_a_valid", 64'(a_valid_in), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_illegal", 64'(illegal_cnt), 64'd0);
        check_output("reset_address", a_address_in, 64'd0);

        $display("[TB] single Get issue");
        apply_stimulus(3'd4, 64'h1000, 3'd2);
        check_output("get_not_yet", 64'(a_valid_in), 64'd0);
        step(1);
        check_output("get_valid", 64'(a_valid_in), 64'd1);
        check_output("get_address", a_address_in, 64'h1000);
        check_output("get_source", 64'(a_source_in), 64'd2);
        check_output("get_opcode", 64'(a_opcode_in), 64'd4);
        step(1);
        check_output("get_pulse_end", 64'(a_valid_in), 64'd0);
        check_output("get_busy_wait", 64'(busy), 64'd1);
        d_manual = 1;
        step(1);
        d_manual = 0;
        check_output("get_busy_done", 64'(busy), 64'd0);

        $display("[TB] d_fire outside WAIT");
        apply_stimulus(3'd0, 64'h2000, 3'd1);
        d_manual = 1;
        step(2);
        d_manual = 0;
        step(3);
        check_output("dfire_ignored_busy", 64'(busy), 64'd1);
        check_output("dfire_ignored_valid", 64'(a_valid_in), 64'd0);
        d_manual = 1;
        step(1);
        d_manual = 0;
        step(1);
        check_output("dfire_wait_done", 64'(busy), 64'd0);

        $display("[TB] FIFO full");
        for (int i = 0; i < 5; i++) apply_stimulus(3'd0, 64'(32'h3000 + i * 8), 3'(i));
        req_valid = 1'b1;
        check_output("full_ready_low", 64'(req_ready), 64'd0);
        check_output("full_busy", 64'(busy), 64'd1);
        d_auto = 1;
        d_prob = 40;
        apply_stimulus(3'd0, 64'h3100, 3'd5);
        wait_idle();

        $display("[TB] illegal opcode filtering");
        apply_stimulus(3'd2, 64'h4000, 3'd0);
        apply_stimulus(3'd1, 64'h4008, 3'd1);
        apply_stimulus(3'd3, 64'h4010, 3'd2);
        apply_stimulus(3'd7, 64'h4018, 3'd3);
        wait_idle();
        check_output("illegal_count3", 64'(illegal_cnt), 64'd3);

`ifdef TL_REQ_TIMEOUT_EN
        $display("[TB] completion timeout");
        d_auto = 0;
        apply_stimulus(3'd4, 64'h5000, 3'd6);
        step(TMO + 4);
        check_output("timeout_flag", 64'(timeout_err), 64'd1);
        check_output("timeout_idle", 64'(busy), 64'd0);
        d_manual = 1;
        step(1);
        d_manual = 0;
        step(2);
        check_output("timeout_sticky", 64'(timeout_err), 64'd1);
        d_auto = 1;
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) d_prob = int'($urandom_range(20, 90));
            if ($urandom_range(9) < 8) begin
                case ($urandom_range(2))
                    0:       op = 3'd0;
                    1:       op = 3'd1;
                    default: op = 3'd4;
                endcase
            end else begin
                op = 3'd2;
                while (is_legal(op)) op = 3'($urandom_range(7));
            end
            apply_stimulus(op, {$urandom, $urandom}, 3'($urandom_range(7)));
            step(int'($urandom_range(0, 3)));
        end
        wait_idle();

        $display("[TB] illegal counter saturation");
        req_opcode = 3'd7;
        req_valid  = 1'b1;
        step(260);
        req_valid = 1'b0;
        step(1);
        check_output("illegal_saturate", 64'(illegal_cnt), 64'd255);

        $display("[TB] reset during WAIT");
        d_auto = 0;
        d_manual = 0;
        step(1);
        for (int i = 0; i < 3; i++) apply_stimulus(3'd4, 64'(32'h6000 + i * 8), 3'(i));
        check_output("rst_pre_busy", 64'(busy), 64'd1);
        #1 rst = 1'b0;
        #1;
        check_output("rst_a_valid", 64'(a_valid_in), 64'd0);
        check_output("rst_address", a_address_in, 64'd0);
        check_output("rst_opcode", 64'(a_opcode_in), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_ready", 64'(req_ready), 64'd1);
        check_output("rst_illegal", 64'(illegal_cnt), 64'd0);
        check_output("rst_timeout", 64'(timeout_err), 64'd0);
        step(2);
        rst = 1'b1;
        step(10);
        check_output("rst_no_issue", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
